// File: rtl/roe_control_fsm.sv
// roe_control_fsm: multi-cycle control sequencer for a tiny 9-bit ISA.
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// handles memory handshakes with an ack timeout, and parks in HALT on a
// HALT opcode, an illegal opcode, or a timed-out access.
//
// Handshake semantics (instruction and data memory): the block raises a
// request strobe (imem_req, dmem_read or dmem_write) and holds it high every
// cycle until the memory answers with a one-cycle ack. The ack is consumed
// on the rising edge where both strobe and ack are high; the strobe is low
// from the following cycle. An ack seen while no strobe is pending is
// ignored. If ACK_TIMEOUT cycles pass without an ack, the access is abandoned
// and the block halts with err=1.
module roe_control_fsm #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [8:0] imem_data,
    output logic [7:0] pc,
    output logic [1:0] alu_src,
    output logic [3:0] to_ext,
    output logic [3:0] to_inc,
    output logic [1:0] rs,
    input  logic       alu_zero,
    output logic       dmem_read,
    output logic       dmem_write,
    input  logic       dmem_ack,
    output logic       reg_write,
    output logic       halted,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_INCI  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_BEQZ  = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state, state_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       imm_q, imm_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       pc_d;
    logic [1:0]       alu_src_d;
    logic [1:0]       rs_d;
    logic             err_d;
    logic             imem_req_d, dmem_read_d, dmem_write_d, reg_write_d, halted_d;

    // Operand-select encoding for each opcode; non-ALU opcodes select zero-ext imm.
    function automatic logic [1:0] src_of(input logic [2:0] op);
        case (op)
            OP_ADDI:                            src_of = 2'b00;
            OP_INCI:                            src_of = 2'b01;
            OP_ADD, OP_LOAD, OP_STORE, OP_BEQZ: src_of = 2'b10;
            default:                            src_of = 2'b00;
        endcase
    endfunction

    assign to_ext    = imm_q;
    assign to_inc    = imm_q;
    assign state_dbg = state;

    // Next-state, next-pc, decode fields and next registered strobes.
    always_comb begin
        state_d   = state;
        op_d      = op_q;
        imm_d     = imm_q;
        tmo_d     = '0;
        pc_d      = pc;
        alu_src_d = alu_src;
        rs_d      = rs;
        err_d     = err;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = 8'd0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d   = S_DECODE;
                    op_d      = imem_data[8:6];
                    imm_d     = imem_data[3:0];
                    rs_d      = imem_data[5:4];
                    alu_src_d = src_of(imem_data[8:6]);
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_ADDI, OP_INCI: state_d = S_WB;
                    OP_LOAD, OP_STORE:        state_d = S_MEM;
                    OP_BEQZ: begin
                        state_d = S_FETCH;
                        pc_d    = alu_zero ? pc + {4'b0000, imm_q} : pc + 8'd1;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc + 8'd1;
                    end
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered copies of what the next state demands.
        imem_req_d   = (state_d == S_FETCH);
        dmem_read_d  = (state_d == S_MEM) && (op_d == OP_LOAD);
        dmem_write_d = (state_d == S_MEM) && (op_d == OP_STORE);
        reg_write_d  = (state_d == S_WB);
        halted_d     = (state_d == S_HALT);
    end

    // State and output registers; reset overrides start and acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= 3'b000;
            imm_q      <= 4'd0;
            tmo_q      <= '0;
            pc         <= 8'd0;
            alu_src    <= 2'b00;
            rs         <= 2'b00;
            err        <= 1'b0;
            imem_req   <= 1'b0;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            reg_write  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            tmo_q      <= tmo_d;
            pc         <= pc_d;
            alu_src    <= alu_src_d;
            rs         <= rs_d;
            err        <= err_d;
            imem_req   <= imem_req_d;
            dmem_read  <= dmem_read_d;
            dmem_write <= dmem_write_d;
            reg_write  <= reg_write_d;
            halted     <= halted_d;
        end
    end

endmodule

// File: tb/tb_roe_control_fsm.sv
// tb_roe_control_fsm: directed and randomized checks of roe_control_fsm
// against an instruction-level reference model (pc arithmetic, decode table,
// strobe durations) acting as both instruction and data memory.
module tb_roe_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       imem_req;
    logic       imem_ack = 1'b0;
    logic [8:0] imem_data = 9'd0;
    logic [7:0] pc;
    logic [1:0] alu_src;
    logic [3:0] to_ext;
    logic [3:0] to_inc;
    logic [1:0] rs;
    logic       alu_zero = 1'b0;
    logic       dmem_read;
    logic       dmem_write;
    logic       dmem_ack = 1'b0;
    logic       reg_write;
    logic       halted;
    logic       err;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int mpc = 0;

    roe_control_fsm #(.ACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .pc(pc), .alu_src(alu_src), .to_ext(to_ext), .to_inc(to_inc), .rs(rs),
        .alu_zero(alu_zero), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_ack(dmem_ack), .reg_write(reg_write), .halted(halted), .err(err),
        .state_dbg(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode table.
    function automatic logic [1:0] ref_src(input int op);
        case (op)
            1:       return 2'b00;
            2:       return 2'b01;
            0, 3, 4, 5: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        mpc = 0;
        chk("start_req", imem_req, 1);
        chk("start_pc", pc, 0);
        chk("start_err", err, 0);
        chk("start_halted", halted, 0);
    endtask

    // Execute one instruction: id = cycles before imem_ack, dd = cycles before dmem_ack.
    task automatic run_instr(input logic [8:0] inst, input int id, input int dd, input logic z);
        int op;
        int imm;
        int lat;
        int hi;
        op  = int'(inst[8:6]);
        imm = int'(inst[3:0]);
        chk("fetch_req", imem_req, 1);
        chk("fetch_pc", pc, mpc);
        lat = 0;
        for (int i = 0; i < id; i++) begin
            step();
            lat++;
            chk("fetch_req_hold", imem_req, 1);
        end
        imem_ack = 1'b1;
        imem_data = inst;
        step();
        lat++;
        imem_ack = 1'b0;
        imem_data = 9'($urandom);
        chk("decode_req_low", imem_req, 0);
        chk("alu_src", alu_src, ref_src(op));
        chk("to_ext", to_ext, imm);
        chk("to_inc", to_inc, imm);
        chk("rs", rs, inst[5:4]);
        start = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        imem_ack = 1'($urandom_range(0, 1));
        step();
        lat++;
        start = 1'b0;
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        alu_zero = z;
        chk("exec_strobes", {imem_req, dmem_read, dmem_write, reg_write, halted}, 0);
        step();
        lat++;
        alu_zero = 1'($urandom_range(0, 1));
        if (op <= 2) begin
            chk("wb_reg_write", reg_write, 1);
            chk("wb_src_stable", alu_src, ref_src(op));
            step();
            lat++;
            chk("wb_pulse_end", reg_write, 0);
            mpc = (mpc + 1) % 256;
            if (id == 0) chk("alu_latency", lat, 4);
        end else if (op == 3 || op == 4) begin
            hi = 0;
            for (int i = 0; i < dd; i++) begin
                hi += (op == 3) ? int'(dmem_read) : int'(dmem_write);
                chk("mem_no_wb", reg_write, 0);
                step();
            end
            hi += (op == 3) ? int'(dmem_read) : int'(dmem_write);
            chk("mem_rs_stable", rs, inst[5:4]);
            dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
            chk("mem_strobe_cycles", hi, dd + 1);
            chk("mem_strobe_drop", {dmem_read, dmem_write}, 0);
            if (op == 3) begin
                chk("load_reg_write", reg_write, 1);
                step();
                chk("load_wb_end", reg_write, 0);
            end else begin
                chk("store_no_wb", reg_write, 0);
            end
            mpc = (mpc + 1) % 256;
        end else if (op == 5) begin
            mpc = z ? (mpc + imm) % 256 : (mpc + 1) % 256;
        end
        if (op <= 5) begin
            chk("next_fetch_req", imem_req, 1);
            chk("next_pc", pc, mpc);
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk("halt_halted", halted, 1);
                chk("halt_err", err, (op == 6) ? 1 : 0);
                chk("halt_strobes", {imem_req, dmem_read, dmem_write, reg_write}, 0);
                chk("halt_pc", pc, mpc);
                imem_ack = 1'($urandom_range(0, 1));
                dmem_ack = 1'($urandom_range(0, 1));
                step();
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
            end
        end
    endtask

    // Fetch a LOAD/STORE with immediate ack and stop at the first MEM cycle.
    task automatic to_mem(input logic [8:0] inst);
        chk("tomem_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_data = inst;
        step();
        imem_ack = 1'b0;
        step();
        alu_zero = 1'b0;
        step();
    endtask

    // Steer pc to a target with taken branches.
    task automatic goto_pc(input int target);
        int d;
        for (int k = 0; k < 40 && mpc != target; k++) begin
            d = (target - mpc + 256) % 256;
            if (d > 15) d = 15;
            run_instr({3'b101, 2'b01, 4'(d)}, 0, 0, 1'b1);
        end
        chk("goto_pc", pc, target);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_fields"}, {alu_src, to_ext, to_inc, rs}, 0);
        chk({tag, "_strobes"}, {imem_req, dmem_read, dmem_write, reg_write}, 0);
        chk({tag, "_flags"}, {halted, err}, 0);
    endtask

    initial begin
        int op;
        // Reset.
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;
        step();
        chk("idle_no_start", imem_req, 0);

        // Directed instructions.
        do_start();
        run_instr(9'b001_00_0101, 0, 0, 1'b0);
        chk("addi_pc1", pc, 1);
        run_instr(9'b010_10_1111, 0, 0, 1'b0);
        run_instr(9'b000_11_0011, 2, 0, 1'b1);
        run_instr(9'b011_01_0110, 0, 3, 1'b0);
        run_instr(9'b100_10_1001, 1, 2, 1'b0);
        run_instr(9'b000_01_0000, 7, 0, 1'b0);
        run_instr(9'b101_00_0000, 0, 0, 1'b1);

        // Randomized instruction stream (halting opcodes excluded).
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            run_instr({3'(op), 6'($urandom)}, $urandom_range(0, 4),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Branch wrap-around.
        goto_pc(250);
        run_instr(9'b101_00_1000, 0, 0, 1'b0);
        chk("beqz_not_taken", pc, 251);
        goto_pc(250);
        run_instr(9'b101_00_1000, 0, 0, 1'b1);
        chk("beqz_wrap", pc, 2);

        // Illegal opcode and HALT opcode.
        run_instr(9'b110_00_0000, 0, 0, 1'b0);
        do_start();
        run_instr(9'b000_00_0001, 0, 0, 1'b0);
        run_instr(9'b111_00_0000, 0, 0, 1'b0);
        do_start();

        // Instruction fetch timeout.
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tmo_fetch_wait", imem_req, 1);
        end
        step();
        chk("tmo_fetch_halted", halted, 1);
        chk("tmo_fetch_err", err, 1);
        chk("tmo_fetch_req", imem_req, 0);
        do_start();

        // Data memory timeout.
        run_instr(9'b000_00_0000, 0, 0, 1'b0);
        to_mem(9'b011_00_0000);
        for (int i = 0; i < 7; i++) begin
            chk("tmo_mem_wait", dmem_read, 1);
            step();
        end
        chk("tmo_mem_last", dmem_read, 1);
        step();
        chk("tmo_mem_halted", halted, 1);
        chk("tmo_mem_err", err, 1);
        chk("tmo_mem_read", dmem_read, 0);
        chk("tmo_mem_pc", pc, mpc);
        do_start();

        // Reset during MEM wins over dmem_ack.
        run_instr(9'b000_00_0000, 0, 0, 1'b0);
        run_instr(9'b001_00_0000, 0, 0, 1'b0);
        to_mem(9'b100_11_1010);
        chk("mem_write_high", dmem_write, 1);
        reset = 1'b1;
        dmem_ack = 1'b1;
        step();
        reset = 1'b0;
        dmem_ack = 1'b0;
        mpc = 0;
        chk_reset_state("rst_mem");
        step();
        chk("rst_mem_idle", imem_req, 0);

        // Reset during FETCH wins over imem_ack; reset wins over start.
        do_start();
        run_instr(9'b000_00_0000, 0, 0, 1'b0);
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_data = 9'b001_11_1111;
        step();
        reset = 1'b1;
        imem_ack = 1'b0;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk_reset_state("rst_fetch");
        step();
        chk("rst_start_idle", imem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
